// File: rtl/dma_pkg.sv
// dma_pkg: shared constants for the scratchpad DMA engine.
// FSM encodings, register selects, status bits and widths.
package dma_pkg;

  localparam int ADDR_W = 9;
  localparam int SIZE_W = 10;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQUEST = 3'd1;
  localparam logic [2:0] S_BEGIN   = 3'd2;
  localparam logic [2:0] S_READ    = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_END     = 3'd5;

  localparam logic [2:0] REG_BUS_ADDR = 3'd1;
  localparam logic [2:0] REG_MEM_ADDR = 3'd2;
  localparam logic [2:0] REG_SIZE     = 3'd3;
  localparam logic [2:0] REG_BURST    = 3'd4;
  localparam logic [2:0] REG_CTRL     = 3'd5;

  localparam int CTRL_B2M  = 0;
  localparam int CTRL_M2B  = 1;
  localparam int STAT_BUSY = 0;
  localparam int STAT_ERR  = 1;

  // beats-1 of the next burst: min(burst+1, remaining)-1
  function automatic logic [7:0] burst_len(
    input logic [7:0]        burst,
    input logic [SIZE_W-1:0] remaining
  );
    logic [SIZE_W-1:0] beats;
    beats = {2'b00, burst} + 10'd1;
    if (remaining > beats)
      burst_len = burst;
    else
      burst_len = 8'(remaining - 10'd1);
  endfunction

endpackage

// File: rtl/dma_burst_master.sv
// dma_burst_master: runs one bus burst from REQUEST to END.
// Drives the bus master signals and SSRAM port B.
module dma_burst_master
  import dma_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic              abort,
  input  logic [7:0]        burst,
  input  logic [SIZE_W-1:0] remaining,
  input  logic [31:0]       bus_addr,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        state,
  output logic              beat,
  output logic [8:0]        ramAddressB,
  output logic [31:0]       ramDataOutB,
  output logic              ramWriteEnableB,
  input  logic [31:0]       ramDataInB,
  output logic              busRequest,
  input  logic              busGrant,
  output logic              busBeginTransaction,
  output logic [31:0]       busAddress,
  output logic [7:0]        busBurstSize,
  output logic              busReadN,
  input  logic [31:0]       busDataIn,
  input  logic              busDataValidIn,
  input  logic              busEndTransactionIn,
  output logic [31:0]       busDataOut,
  output logic              busDataValidOut,
  input  logic              busBusyIn,
  output logic              busEndTransactionOut
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [8:0] beats_q;
  logic [7:0] len;
  logic       rd_beat;

  assign state   = state_q;
  assign len     = burst_len(burst, remaining);
  assign rd_beat = busDataValidIn && (remaining != '0);

  // next-state: burst sequencing, abort wins over everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_REQUEST;
      S_REQUEST: if (busGrant) state_d = S_BEGIN;
      S_BEGIN:   state_d = dir ? S_WRITE : S_READ;
      S_READ:    if (busEndTransactionIn) state_d = S_END;
      S_WRITE:
        if (!busBusyIn && beats_q == 9'd1)
          state_d = S_END;
      S_END:
        state_d = (remaining != '0) ? S_REQUEST : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE)
      state_d = S_IDLE;
  end

  // state and write-beat countdown
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_BEGIN)
        beats_q <= {1'b0, len} + 9'd1;
      else if (state_q == S_WRITE && !busBusyIn)
        beats_q <= beats_q - 9'd1;
    end
  end

  // bus and SSRAM outputs; write path prefetches the next word
  always_comb begin
    busRequest           = 1'b0;
    busBeginTransaction  = 1'b0;
    busAddress           = '0;
    busBurstSize         = '0;
    busReadN             = 1'b0;
    busDataOut           = '0;
    busDataValidOut      = 1'b0;
    busEndTransactionOut = 1'b0;
    ramAddressB          = '0;
    ramDataOutB          = '0;
    ramWriteEnableB      = 1'b0;
    beat                 = 1'b0;
    case (state_q)
      S_REQUEST: busRequest = 1'b1;
      S_BEGIN: begin
        busRequest          = 1'b1;
        busBeginTransaction = 1'b1;
        busAddress          = bus_addr;
        busBurstSize        = len;
        busReadN            = dir;
        ramAddressB         = mem_addr;
      end
      S_READ: begin
        busRequest  = 1'b1;
        ramAddressB = mem_addr;
        beat        = rd_beat;
        if (rd_beat) begin
          ramWriteEnableB = 1'b1;
          ramDataOutB     = busDataIn;
        end
      end
      S_WRITE: begin
        busRequest      = 1'b1;
        busDataValidOut = 1'b1;
        busDataOut      = ramDataInB;
        beat            = !busBusyIn;
        ramAddressB     = busBusyIn ? mem_addr
                                    : mem_addr + 9'd1;
      end
      S_END: begin
        busRequest           = 1'b1;
        busEndTransactionOut = dir;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dma_transfer_engine.sv
// dma_transfer_engine: CI-programmed block DMA, bus <-> scratchpad.
// Optional DMA_BUS_ERROR_EN: busErrorIn aborts and sets status bit1.
module dma_transfer_engine
  import dma_pkg::*;
#(
  parameter logic [7:0] customId = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult,
  output logic [8:0]  ramAddressB,
  output logic [31:0] ramDataOutB,
  output logic        ramWriteEnableB,
  input  logic [31:0] ramDataInB,
  output logic        busRequest,
  input  logic        busGrant,
  output logic        busBeginTransaction,
  output logic [31:0] busAddress,
  output logic [7:0]  busBurstSize,
  output logic        busReadN,
  input  logic [31:0] busDataIn,
  input  logic        busDataValidIn,
  input  logic        busEndTransactionIn,
  output logic [31:0] busDataOut,
  output logic        busDataValidOut,
  input  logic        busBusyIn,
  output logic        busEndTransactionOut,
  input  logic        busErrorIn
);

  logic [31:0]       bus_addr_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [SIZE_W-1:0] size_reg;
  logic [7:0]        burst_reg;
  logic [31:0]       cur_bus;
  logic [ADDR_W-1:0] cur_mem;
  logic [SIZE_W-1:0] remaining;
  logic              dir_q;
  logic              error_q;
  logic [2:0]        state;
  logic              beat;
  logic              abort;
  logic              busy;
  logic              ci_active;
  logic              ci_write;
  logic [2:0]        sel;
  logic              ctrl_wr;
  logic              go_b2m;
  logic              go_m2b;
  logic              start;
  logic [31:0]       rdata;
  logic              unused_a;

`ifdef DMA_BUS_ERROR_EN
  assign abort = busErrorIn;
`else
  logic unused_err;
  assign abort      = 1'b0;
  assign unused_err = busErrorIn;
`endif

  assign unused_a  = ^ciValueA[8:0];
  assign ci_active = ciStart && (ciN == customId)
                  && (ciValueA[31:13] == 19'd0);
  assign sel       = ciValueA[12:10];
  assign ci_write  = ci_active && ciValueA[9];
  assign busy      = (state != S_IDLE);
  assign ctrl_wr   = ci_write && (sel == REG_CTRL) && !busy;
  assign go_b2m    = ctrl_wr && ciValueB[CTRL_B2M];
  assign go_m2b    = ctrl_wr && !ciValueB[CTRL_B2M]
                  && ciValueB[CTRL_M2B];
  assign start     = (go_b2m || go_m2b) && (size_reg != '0);
  assign ciDone    = ci_active;
  assign ciResult  = ci_active ? rdata : '0;

  // CI register read mux
  always_comb begin
    rdata = '0;
    case (sel)
      REG_BUS_ADDR: rdata = bus_addr_reg;
      REG_MEM_ADDR: rdata = {23'd0, mem_addr_reg};
      REG_SIZE:     rdata = {22'd0, size_reg};
      REG_BURST:    rdata = {24'd0, burst_reg};
      REG_CTRL: begin
        rdata[STAT_BUSY] = busy;
        rdata[STAT_ERR]  = error_q;
      end
      default:      rdata = '0;
    endcase
  end

  // programmed registers, frozen while a transfer runs
  always_ff @(posedge clock) begin
    if (!reset) begin
      bus_addr_reg <= '0;
      mem_addr_reg <= '0;
      size_reg     <= '0;
      burst_reg    <= '0;
    end else if (ci_write && !busy) begin
      case (sel)
        REG_BUS_ADDR: bus_addr_reg <= {ciValueB[31:2], 2'b00};
        REG_MEM_ADDR: mem_addr_reg <= ciValueB[ADDR_W-1:0];
        REG_SIZE:     size_reg     <= ciValueB[SIZE_W-1:0];
        REG_BURST:    burst_reg    <= ciValueB[7:0];
        default: ;
      endcase
    end
  end

  // working copies: loaded at start, stepped once per beat
  always_ff @(posedge clock) begin
    if (!reset) begin
      cur_bus   <= '0;
      cur_mem   <= '0;
      remaining <= '0;
      dir_q     <= 1'b0;
    end else if (start) begin
      cur_bus   <= bus_addr_reg;
      cur_mem   <= mem_addr_reg;
      remaining <= size_reg;
      dir_q     <= go_m2b;
    end else if (beat) begin
      cur_bus <= cur_bus + 32'd4;
      cur_mem <= cur_mem + 9'd1;
      if (remaining != '0)
        remaining <= remaining - 10'd1;
    end
  end

  // sticky error flag, cleared by the next real start
  always_ff @(posedge clock) begin
    if (!reset)
      error_q <= 1'b0;
    else if (start)
      error_q <= 1'b0;
    else if (abort && busy)
      error_q <= 1'b1;
  end

  dma_burst_master u_burst (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .dir                  (dir_q),
    .abort                (abort),
    .burst                (burst_reg),
    .remaining            (remaining),
    .bus_addr             (cur_bus),
    .mem_addr             (cur_mem),
    .state                (state),
    .beat                 (beat),
    .ramAddressB          (ramAddressB),
    .ramDataOutB          (ramDataOutB),
    .ramWriteEnableB      (ramWriteEnableB),
    .ramDataInB           (ramDataInB),
    .busRequest           (busRequest),
    .busGrant             (busGrant),
    .busBeginTransaction  (busBeginTransaction),
    .busAddress           (busAddress),
    .busBurstSize         (busBurstSize),
    .busReadN             (busReadN),
    .busDataIn            (busDataIn),
    .busDataValidIn       (busDataValidIn),
    .busEndTransactionIn  (busEndTransactionIn),
    .busDataOut           (busDataOut),
    .busDataValidOut      (busDataValidOut),
    .busBusyIn            (busBusyIn),
    .busEndTransactionOut (busEndTransactionOut)
  );

endmodule

// File: tb/tb_dma_transfer_engine.sv
// tb_dma_transfer_engine: directed vectors for the DMA engine.
// SSRAM port B and the bus slave are modelled here.
module tb_dma_transfer_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        ciStart;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;
  logic [8:0]  ramAddressB;
  logic [31:0] ramDataOutB;
  logic        ramWriteEnableB;
  logic [31:0] ramDataInB;
  logic        busRequest;
  logic        busGrant;
  logic        busBeginTransaction;
  logic [31:0] busAddress;
  logic [7:0]  busBurstSize;
  logic        busReadN;
  logic [31:0] busDataIn;
  logic        busDataValidIn;
  logic        busEndTransactionIn;
  logic [31:0] busDataOut;
  logic        busDataValidOut;
  logic        busBusyIn;
  logic        busEndTransactionOut;
  logic        busErrorIn;

  logic [31:0] mem [0:511];
  logic        tb_we;
  logic [8:0]  tb_wa;
  logic [31:0] tb_wd;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] r;
  logic        dn;
  logic        any_out;

  always #5 clock = ~clock;

  dma_transfer_engine dut (
    .clock                (clock),
    .reset                (reset),
    .ciStart              (ciStart),
    .ciN                  (ciN),
    .ciValueA             (ciValueA),
    .ciValueB             (ciValueB),
    .ciDone               (ciDone),
    .ciResult             (ciResult),
    .ramAddressB          (ramAddressB),
    .ramDataOutB          (ramDataOutB),
    .ramWriteEnableB      (ramWriteEnableB),
    .ramDataInB           (ramDataInB),
    .busRequest           (busRequest),
    .busGrant             (busGrant),
    .busBeginTransaction  (busBeginTransaction),
    .busAddress           (busAddress),
    .busBurstSize         (busBurstSize),
    .busReadN             (busReadN),
    .busDataIn            (busDataIn),
    .busDataValidIn       (busDataValidIn),
    .busEndTransactionIn  (busEndTransactionIn),
    .busDataOut           (busDataOut),
    .busDataValidOut      (busDataValidOut),
    .busBusyIn            (busBusyIn),
    .busEndTransactionOut (busEndTransactionOut),
    .busErrorIn           (busErrorIn)
  );

  // SSRAM model: 1-cycle read, tb preload port
  always @(posedge clock) begin
    if (tb_we)
      mem[tb_wa] <= tb_wd;
    else if (ramWriteEnableB)
      mem[ramAddressB] <= ramDataOutB;
    ramDataInB <= mem[ramAddressB];
  end

  assign any_out = ciDone | (|ciResult) | (|ramAddressB)
    | (|ramDataOutB) | ramWriteEnableB | busRequest
    | busBeginTransaction | (|busAddress) | (|busBurstSize)
    | busReadN | (|busDataOut) | busDataValidOut
    | busEndTransactionOut;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [8:0] a,
                         input logic [31:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    step();
    tb_we = 1'b0;
  endtask

  task automatic ci(input logic [2:0] sel,
                    input logic wr,
                    input logic [31:0] d);
    ciStart  = 1'b1;
    ciN      = 8'h00;
    ciValueA = {19'd0, sel, wr, 9'd0};
    ciValueB = d;
    #1;
    r  = ciResult;
    dn = ciDone;
    step();
    ciStart  = 1'b0;
    ciValueA = '0;
    ciValueB = '0;
  endtask

  // wait for request, grant, check BEGIN, move to data phase
  task automatic grant_begin(input string tag,
                             input logic [31:0] a,
                             input logic [7:0] len,
                             input logic rn,
                             input logic [8:0] m);
    int n = 0;
    while (!busRequest && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"}, 32'(busRequest), 32'd1);
    busGrant = 1'b1;
    step();
    busGrant = 1'b0;
    chk({tag, "_beg"}, 32'(busBeginTransaction), 32'd1);
    chk({tag, "_addr"}, busAddress, a);
    chk({tag, "_len"}, 32'(busBurstSize), 32'(len));
    chk({tag, "_rn"}, 32'(busReadN), 32'(rn));
    chk({tag, "_ma"}, 32'(ramAddressB), 32'(m));
    step();
  endtask

  task automatic read_beats(input string tag,
                            input int n,
                            input int idx0,
                            input int m0,
                            input bit fin,
                            input int err_at);
    for (int j = 0; j < n; j++) begin
      busDataValidIn      = 1'b1;
      busDataIn           = 32'hA000_0000 + 32'(idx0 + j);
      busEndTransactionIn = fin && (j == n - 1);
      busErrorIn          = (j == err_at);
      #1;
      chk({tag, "_we"}, 32'(ramWriteEnableB), 32'd1);
      chk({tag, "_wa"}, 32'(ramAddressB),
          32'((m0 + j) % 512));
      step();
    end
    busDataValidIn      = 1'b0;
    busEndTransactionIn = 1'b0;
    busErrorIn          = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ciStart = 1'b0; ciN = '0;
    ciValueA = '0; ciValueB = '0; busGrant = 1'b0;
    busDataIn = '0; busDataValidIn = 1'b0;
    busEndTransactionIn = 1'b0; busBusyIn = 1'b0;
    busErrorIn = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;

    preload(9'd4,   32'hDEAD_0004);
    preload(9'd15,  32'hDEAD_0015);
    preload(9'd510, 32'h1111_0510);
    preload(9'd511, 32'h1111_0511);
    preload(9'd0,   32'h1111_0000);
    chk("rst_outs", 32'(any_out), 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    reset = 1'b1;
    step();

    // register round trip and decode
    ci(3'd1, 1'b1, 32'h0000_1003);
    chk("wr1_done", 32'(dn), 32'd1);
    ci(3'd1, 1'b0, 32'h0);
    chk("rd1_val", r, 32'h0000_1000);
    chk("rd1_done", 32'(dn), 32'd1);
    ci(3'd6, 1'b1, 32'hFFFF_FFFF);
    ci(3'd6, 1'b0, 32'h0);
    chk("rd6_val", r, 32'h0);
    chk("rd6_done", 32'(dn), 32'd1);
    ciStart = 1'b1; ciN = 8'h01; ciValueA = {19'd0, 3'd1, 10'd0};
    #1;
    chk("badn_done", 32'(ciDone), 32'd0);
    chk("badn_res", ciResult, 32'd0);
    ciStart = 1'b0; ciN = 8'h00; ciValueA = '0;
    step();

    // bus -> mem: 10 words, 4-beat bursts
    ci(3'd1, 1'b1, 32'h100);
    ci(3'd2, 1'b1, 32'd5);
    ci(3'd3, 1'b1, 32'd10);
    ci(3'd4, 1'b1, 32'd3);
    ci(3'd5, 1'b1, 32'd1);
    ci(3'd5, 1'b0, 32'd0);
    chk("b2m_busy", r, 32'h1);
    grant_begin("b2m0", 32'h100, 8'd3, 1'b0, 9'd5);
    read_beats("b2m0", 4, 0, 5, 1'b1, -1);
    step();
    grant_begin("b2m1", 32'h110, 8'd3, 1'b0, 9'd9);
    read_beats("b2m1", 4, 4, 9, 1'b1, -1);
    step();
    grant_begin("b2m2", 32'h120, 8'd1, 1'b0, 9'd13);
    read_beats("b2m2", 2, 8, 13, 1'b1, -1);
    chk("b2m_endreq", 32'(busRequest), 32'd1);
    step();
    chk("b2m_idle_req", 32'(busRequest), 32'd0);
    ci(3'd5, 1'b0, 32'd0);
    chk("b2m_done", r, 32'h0);
    ci(3'd3, 1'b0, 32'd0);
    chk("b2m_size_kept", r, 32'd10);
    for (int i = 0; i < 10; i++)
      chk("b2m_mem", mem[5 + i], 32'hA000_0000 + 32'(i));
    chk("b2m_mem4", mem[4], 32'hDEAD_0004);
    chk("b2m_mem15", mem[15], 32'hDEAD_0015);

    // mem -> bus: 3 words from 510, busy stall on beat 2
    ci(3'd1, 1'b1, 32'h200);
    ci(3'd2, 1'b1, 32'd510);
    ci(3'd3, 1'b1, 32'd3);
    ci(3'd4, 1'b1, 32'd7);
    ci(3'd5, 1'b1, 32'd2);
    grant_begin("m2b", 32'h200, 8'd2, 1'b1, 9'd510);
    chk("m2b_v1", 32'(busDataValidOut), 32'd1);
    chk("m2b_d1", busDataOut, 32'h1111_0510);
    chk("m2b_a1", 32'(ramAddressB), 32'd511);
    step();
    for (int k = 0; k < 3; k++) begin
      busBusyIn = (k < 2);
      #1;
      chk("m2b_v2", 32'(busDataValidOut), 32'd1);
      chk("m2b_d2", busDataOut, 32'h1111_0511);
      chk("m2b_a2", 32'(ramAddressB), (k < 2) ? 32'd511 : 32'd0);
      chk("m2b_eot2", 32'(busEndTransactionOut), 32'd0);
      step();
    end
    busBusyIn = 1'b0;
    chk("m2b_d3", busDataOut, 32'h1111_0000);
    step();
    chk("m2b_eot", 32'(busEndTransactionOut), 32'd1);
    chk("m2b_endv", 32'(busDataValidOut), 32'd0);
    step();
    chk("m2b_eot_off", 32'(busEndTransactionOut), 32'd0);
    chk("m2b_req_off", 32'(busRequest), 32'd0);

    // zero block size is a no-op
    ci(3'd3, 1'b1, 32'd0);
    ci(3'd5, 1'b1, 32'd1);
    step();
    chk("z_req", 32'(busRequest), 32'd0);
    ci(3'd5, 1'b0, 32'd0);
    chk("z_stat", r, 32'd0);

    // start while busy is ignored
    ci(3'd1, 1'b1, 32'h300);
    ci(3'd2, 1'b1, 32'd20);
    ci(3'd3, 1'b1, 32'd2);
    ci(3'd4, 1'b1, 32'd0);
    ci(3'd5, 1'b1, 32'd1);
    ci(3'd1, 1'b1, 32'h999);
    ci(3'd5, 1'b1, 32'd2);
    ci(3'd1, 1'b0, 32'd0);
    chk("wp_reg1", r, 32'h300);
    grant_begin("wp0", 32'h300, 8'd0, 1'b0, 9'd20);
    read_beats("wp0", 1, 50, 20, 1'b1, -1);
    step();
    grant_begin("wp1", 32'h304, 8'd0, 1'b0, 9'd21);
    read_beats("wp1", 1, 51, 21, 1'b1, -1);
    step();
    chk("wp_idle", 32'(busRequest), 32'd0);
    chk("wp_mem20", mem[20], 32'hA000_0032);
    chk("wp_mem21", mem[21], 32'hA000_0033);

    // bus error on beat 2 of a read
    ci(3'd1, 1'b1, 32'h400);
    ci(3'd2, 1'b1, 32'd40);
    ci(3'd3, 1'b1, 32'd4);
    ci(3'd4, 1'b1, 32'd3);
    ci(3'd5, 1'b1, 32'd1);
    grant_begin("er0", 32'h400, 8'd3, 1'b0, 9'd40);
    read_beats("er0", 2, 100, 40, 1'b0, 1);
`ifdef DMA_BUS_ERROR_EN
    chk("er_req", 32'(busRequest), 32'd0);
    ci(3'd5, 1'b0, 32'd0);
    chk("er_stat", r, 32'h2);
    ci(3'd5, 1'b1, 32'd1);
    ci(3'd5, 1'b0, 32'd0);
    chk("er_clr", r, 32'h1);
    grant_begin("er1", 32'h400, 8'd3, 1'b0, 9'd40);
    read_beats("er1", 4, 100, 40, 1'b1, -1);
`else
    chk("er_req", 32'(busRequest), 32'd1);
    read_beats("er1", 2, 102, 42, 1'b1, -1);
`endif
    step();
    ci(3'd5, 1'b0, 32'd0);
    chk("er_final", r, 32'h0);
    for (int i = 0; i < 4; i++)
      chk("er_mem", mem[40 + i], 32'hA000_0064 + 32'(i));

    // reset during WRITE_DATA
    ci(3'd1, 1'b1, 32'h500);
    ci(3'd2, 1'b1, 32'd100);
    ci(3'd3, 1'b1, 32'd2);
    ci(3'd4, 1'b1, 32'd1);
    ci(3'd5, 1'b1, 32'd2);
    grant_begin("rs", 32'h500, 8'd1, 1'b1, 9'd100);
    chk("rs_wr", 32'(busDataValidOut), 32'd1);
    reset = 1'b0;
    step();
    chk("rs_outs", 32'(any_out), 32'd0);
    chk("rs_state", 32'(dut.state), 32'd0);
    reset = 1'b1;
    ci(3'd1, 1'b0, 32'd0);
    chk("rs_r1", r, 32'd0);
    ci(3'd2, 1'b0, 32'd0);
    chk("rs_r2", r, 32'd0);
    ci(3'd3, 1'b0, 32'd0);
    chk("rs_r3", r, 32'd0);
    ci(3'd4, 1'b0, 32'd0);
    chk("rs_r4", r, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_transfer_engine.md
# dma_transfer_engine

Block-transfer DMA engine that moves 32-bit words between the system bus and port B of the 512-entry custom-instruction scratchpad SSRAM. It is programmed through the same custom-instruction interface as the scratchpad, using its own `customId`. It acts as bus master on the shared bus, splitting a block into bursts. It sits directly upstream/downstream of the scratchpad: it fills the scratchpad from external memory or drains it back.

## Interface
- `customId`, 8'h00: custom-instruction opcode this block answers to.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low; all state is cleared on the first rising edge where `reset`=0.
- `ciStart` in 1, `ciN` in 8, `ciValueA` in 32, `ciValueB` in 32: custom-instruction request.
- `ciDone` out 1, `ciResult` out 32: CI completion and read data (0 when `ciDone`=0).
- `ramAddressB` out 9, `ramDataOutB` out 32, `ramWriteEnableB` out 1, `ramDataInB` in 32: SSRAM port B. Read latency is 1 cycle; no read-after-write.
- `busRequest` out 1, `busGrant` in 1: bus arbitration.
- `busBeginTransaction` out 1, `busAddress` out 32, `busBurstSize` out 8 (beats−1), `busReadN` out 1 (0=read): address phase.
- `busDataIn` in 32, `busDataValidIn` in 1, `busEndTransactionIn` in 1: read data.
- `busDataOut` out 32, `busDataValidOut` out 1, `busBusyIn` in 1, `busEndTransactionOut` out 1: write data.
- `busErrorIn` in 1: slave error.

## Operation
- **CI decode.** Active when `ciStart`=1, `ciN`==`customId`, and `ciValueA[31:13]`==0. `ciValueA[12:10]` selects the register; `ciValueA[9]`=1 means write, with data taken from `ciValueB`.
- **Registers** (reset 0):
  - 1: bus start address. Bits [1:0] are forced to 0.
  - 2: memory start address, 9 bits.
  - 3: block size in words, 10 bits.
  - 4: burst size (beats−1), 8 bits.
  - 5: write = control (bit0 start bus→mem, bit1 start mem→bus; bit0 wins if both set). Read = status (bit0 busy, bit1 error).
  - Selects 0, 6 and 7 read 0 and ignore writes.
- **Write protection.** Writes to registers 1–4, and to control, are ignored while busy. A start with block size 0 is a no-op and busy stays 0.
- **FSM:** IDLE → REQUEST → BEGIN → (READ_DATA | WRITE_DATA) → END → REQUEST if words remain, otherwise IDLE.
  - REQUEST: hold `busRequest`=1 until `busGrant`=1.
  - BEGIN: one cycle with `busBeginTransaction`=1. Drive address, `busBurstSize`=min(burst+1, remaining)−1, and `busReadN`.
  - READ_DATA: each `busDataValidIn` writes `busDataIn` to the SSRAM at the current memory address. Leave the state on `busEndTransactionIn`.
  - WRITE_DATA: present one word per cycle with `busDataValidOut`=1. While `busBusyIn`=1, hold the word, the valid flag and the SSRAM address. After the last beat, END drives `busEndTransactionOut`=1 for one cycle.
  - `busRequest` stays high from REQUEST through END.
- **Arithmetic.**
  - Bus address +4 per beat, 32-bit wrap.
  - Memory address +1 per beat, wraps mod 512.
  - Remaining-word count decrements per beat and never underflows.
  - Working copies are loaded at start; programmed registers are unchanged.

## Timing
- **CI:** `ciDone` is combinational in the same cycle as an active `ciStart`. Every access takes 1 cycle.
- **Bus → memory:** each SSRAM write occurs on the same edge that samples `busDataValidIn`.
- **Memory → bus:** the SSRAM read for beat n+1 is issued while beat n is presented, so the first beat follows BEGIN by 1 cycle.
- **Busy flag:** rises on the edge after the start write. It falls on the edge leaving the final END.
- **Reset:** all outputs are 0 after reset, and the FSM is in IDLE. Reset mid-transfer aborts immediately with no end-of-transaction handshake.

## Configuration
- **`DMA_BUS_ERROR_EN` defined:** `busErrorIn`=1 in any bus state aborts the transfer. The FSM goes to IDLE the next cycle, with `busRequest` and valids low. Status bit1 is set and stays set until the next accepted start.
- **Not defined:** `busErrorIn` is ignored and status bit1 always reads 0.

## Structure
- **Package `dma_pkg`:** FSM state enum, register-select constants (1–5), status/control bit positions, and widths (address 9, block size 10).
- **Sub-module `dma_burst_master`:** handles one burst (REQUEST…END, beat counting, busy stall, SSRAM port B).
- **Top level:** handles CI registers, block splitting, and address/remaining bookkeeping.

## Test plan
- **Register round trip:** write reg1=0x0000_1003 then read it back → 0x0000_1000. Read reg6 → 0. Each access gives `ciDone` in the same cycle.
- **Bus→mem, 10 words, burst 3 (4 beats):**
  - expect bursts of 4, 4 and 2;
  - `busAddress` 0x100, 0x110, 0x120;
  - SSRAM[5..14] equals the bus data;
  - busy drops after the third `busEndTransactionIn`.
- **Mem→bus, 3 words from mem 510, `busBusyIn` high for 2 cycles on beat 2:**
  - memory addresses wrap 510, 511, 0;
  - beat 2 data is held stable for 3 cycles;
  - `busEndTransactionOut` pulses once.
- **Start with block size 0:** busy never rises and `busRequest` stays 0. Start while busy is ignored; the transfer completes unchanged.
- **`DMA_BUS_ERROR_EN`:**
  - `busErrorIn` on beat 2 of a read → IDLE, and status reads 0x2.
  - A subsequent start clears the error and the status reads 0x1.
  - Without the macro, the same stimulus completes the transfer normally.
- **Reset low during WRITE_DATA:** on the next edge all outputs are 0, the FSM is in IDLE and the registers are 0.
